// File: rtl/mxn_bits_shift.sv
// -----------------------------------------------------------------------------
// mxn_bits_shift
//   Registered multi-lane barrel shifter for the ALU shift unit. Each of the
//   SETS lanes shifts its own WIDTH-bit word under its own WIDTH-bit control
//   word. It produces the shifted result and an overflow word that holds the
//   bits shifted out. OP selects logical (0) or arithmetic (1) shifting for
//   all lanes.
//
//   Control word per lane: ctrl[0] = direction (0 left, 1 right),
//   ctrl[WIDTH-2:1] = amount (saturates at WIDTH), ctrl[WIDTH-1] = fill bit.
//
// Ports
//   clk             : clock, rising edge
//   rst_n           : synchronous active-low reset, clears both outputs
//   in_packed       : lane k data at [k*WIDTH +: WIDTH]
//   shift_packed    : lane k control word at [k*WIDTH +: WIDTH]
//   out_packed      : lane k shifted result, one cycle latency
//   overflow_packed : lane k shifted-out bits, one cycle latency
// -----------------------------------------------------------------------------
module mxn_bits_shift #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2,
  parameter int OP    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SETS*WIDTH-1:0]   in_packed,
  input  logic [SETS*WIDTH-1:0]   shift_packed,
  output logic [SETS*WIDTH-1:0]   out_packed,
  output logic [SETS*WIDTH-1:0]   overflow_packed
);

  localparam int AW = WIDTH - 2;

  logic [SETS*WIDTH-1:0] res_s;
  logic [SETS*WIDTH-1:0] ovf_s;
  logic [SETS*WIDTH-1:0] out_r;
  logic [SETS*WIDTH-1:0] ovf_r;

  // One lane: returns {ovf, res}. The shift operates on a double-width word,
  // so the shifted-out bits land in the other half with zeros around them.
  // Vacated result bits are then forced to the fill value through a mask.
  function automatic logic [2*WIDTH-1:0] lane_shift(
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] ctrl
  );
    logic                 dir;
    logic [AW-1:0]        amt;
    logic [31:0]          n;
    logic                 f;
    logic [2*WIDTH-1:0]   wide;
    logic [WIDTH-1:0]     ones;
    logic [WIDTH-1:0]     mask;
    logic [WIDTH-1:0]     res;
    logic [WIDTH-1:0]     ovf;
    dir  = ctrl[0];
    amt  = ctrl[WIDTH-2:1];
    ones = {WIDTH{1'b1}};
    n    = 32'(amt);
    if (n > 32'(WIDTH)) begin
      n = 32'(WIDTH);
    end else begin
      n = n;
    end
    // Arithmetic mode: right shifts sign-extend, left shifts fill with zero.
    if (OP == 0) begin
      f = ctrl[WIDTH-1];
    end else if (dir == 1'b1) begin
      f = d[WIDTH-1];
    end else begin
      f = 1'b0;
    end
    if (dir == 1'b0) begin
      wide = {{WIDTH{1'b0}}, d} << n;
      res  = wide[WIDTH-1:0];
      ovf  = wide[2*WIDTH-1:WIDTH];
      mask = ~(ones << n);
    end else begin
      wide = {d, {WIDTH{1'b0}}} >> n;
      res  = wide[2*WIDTH-1:WIDTH];
      ovf  = wide[WIDTH-1:0];
      mask = ~(ones >> n);
    end
    if (f) begin
      res = res | mask;
    end else begin
      res = res;
    end
    return {ovf, res};
  endfunction

  // Combinational shift for every lane, each with its own control word.
  always_comb begin
    res_s = {(SETS*WIDTH){1'b0}};
    ovf_s = {(SETS*WIDTH){1'b0}};
    for (int k = 0; k < SETS; k++) begin
      {ovf_s[k*WIDTH +: WIDTH], res_s[k*WIDTH +: WIDTH]} =
        lane_shift(in_packed[k*WIDTH +: WIDTH], shift_packed[k*WIDTH +: WIDTH]);
    end
  end

  // Output registers: cleared by reset, otherwise loaded every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r <= {(SETS*WIDTH){1'b0}};
      ovf_r <= {(SETS*WIDTH){1'b0}};
    end else begin
      out_r <= res_s;
      ovf_r <= ovf_s;
    end
  end

  assign out_packed      = out_r;
  assign overflow_packed = ovf_r;

endmodule

// File: tb/tb_mxn_bits_shift.sv
// -----------------------------------------------------------------------------
// tb_mxn_bits_shift
//   Drives a logical (OP=0) and an arithmetic (OP=1) instance with the same
//   inputs and compares both against a bit-by-bit reference model.
// -----------------------------------------------------------------------------
module tb_mxn_bits_shift;

  localparam int W = 4;
  localparam int S = 2;
  localparam int N = W * S;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_packed;
  logic [N-1:0] shift_packed;
  logic [N-1:0] out0, ovf0, out1, ovf1;

  int checks;
  int failures;

  mxn_bits_shift #(.WIDTH(W), .SETS(S), .OP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_packed(in_packed), .shift_packed(shift_packed),
    .out_packed(out0), .overflow_packed(ovf0)
  );

  mxn_bits_shift #(.WIDTH(W), .SETS(S), .OP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_packed(in_packed), .shift_packed(shift_packed),
    .out_packed(out1), .overflow_packed(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b in=%b sh=%b", tag, got, exp, in_packed, shift_packed);
    end
  endtask

  // Reference: each result/overflow bit is traced back to its source bit.
  function automatic logic [2*N-1:0] model(input logic [N-1:0] din,
                                           input logic [N-1:0] sh, input int op);
    logic [N-1:0] o, v;
    o = '0;
    v = '0;
    for (int k = 0; k < S; k++) begin
      logic [W-1:0] d, c;
      int dir, amt, n, fbit, fv;
      d = din[k*W +: W];
      c = sh[k*W +: W];
      dir  = int'(c[0]);
      amt  = int'(c[W-2:1]);
      fbit = int'(c[W-1]);
      n    = (amt > W) ? W : amt;
      if (op == 0) fv = fbit;
      else if (dir == 1) fv = int'(d[W-1]);
      else fv = 0;
      for (int i = 0; i < W; i++) begin
        if (dir == 0) begin
          o[k*W+i] = (i - n >= 0) ? d[i-n] : fv[0];
          v[k*W+i] = (i < n) ? d[W+i-n] : 1'b0;
        end else begin
          o[k*W+i] = (i + n < W) ? d[i+n] : fv[0];
          v[k*W+i] = (i + n >= W) ? d[i+n-W] : 1'b0;
        end
      end
    end
    return {v, o};
  endfunction

  // Apply one input pair, clock it in, then compare both instances.
  task automatic apply(input logic [N-1:0] din, input logic [N-1:0] sh, input string tag);
    logic [2*N-1:0] e0, e1;
    in_packed    = din;
    shift_packed = sh;
    e0 = model(din, sh, 0);
    e1 = model(din, sh, 1);
    @(posedge clk);
    #1;
    check({tag, "_out0"}, out0, e0[N-1:0]);
    check({tag, "_ovf0"}, ovf0, e0[2*N-1:N]);
    check({tag, "_out1"}, out1, e1[N-1:0]);
    check({tag, "_ovf1"}, ovf1, e1[2*N-1:N]);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with nonzero inputs held for two edges.
    rst_n        = 1'b0;
    in_packed    = 8'b1011_0110;
    shift_packed = 8'b1101_0010;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out0", out0, 8'h00);
    check("rst_ovf0", ovf0, 8'h00);
    check("rst_out1", out1, 8'h00);
    check("rst_ovf1", ovf1, 8'h00);
    rst_n = 1'b1;
    apply(8'b1011_0110, 8'b1101_0010, "post_rst");

    // Logical: lane0 left 1 fill 0, lane1 right 2 fill 1.
    apply(8'b1011_1011, 8'b1101_0010, "dir1");
    check("d1_l0_out", {4'b0000, out0[3:0]}, 8'b0000_0110);
    check("d1_l0_ovf", {4'b0000, ovf0[3:0]}, 8'b0000_0001);
    check("d1_l1_out", {4'b0000, out0[7:4]}, 8'b0000_1110);
    check("d1_l1_ovf", {4'b0000, ovf0[7:4]}, 8'b0000_1100);

    // Logical: lane0 left 1 fill 1.
    apply(8'b1011_1011, 8'b1101_1010, "dir2");
    check("d2_l0_out", {4'b0000, out0[3:0]}, 8'b0000_0111);
    check("d2_l0_ovf", {4'b0000, ovf0[3:0]}, 8'b0000_0001);

    // Arithmetic: lane0 right 3 of 1001, lane1 right 1 of 0110 with fill set.
    apply(8'b0110_1001, 8'b1011_0111, "dir3");
    check("d3_l0_out", {4'b0000, out1[3:0]}, 8'b0000_1111);
    check("d3_l0_ovf", {4'b0000, ovf1[3:0]}, 8'b0000_0010);
    check("d3_l1_out", {4'b0000, out1[7:4]}, 8'b0000_0011);
    check("d3_l1_ovf", {4'b0000, ovf1[7:4]}, 8'b0000_0000);

    // Zero amount passes data through in both modes.
    apply(8'b1010_1010, 8'b0000_1001, "dir4");
    check("d4_out0", out0, 8'b1010_1010);
    check("d4_ovf0", ovf0, 8'b0000_0000);
    check("d4_out1", out1, 8'b1010_1010);
    check("d4_ovf1", ovf1, 8'b0000_0000);

    // Sweep: every lane0 input x every control word, lane1 randomized,
    // new values every cycle.
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] a, b, l1d, l1c;
        a   = 4'(i);
        b   = 4'(c);
        l1d = 4'($urandom_range(0, 15));
        l1c = 4'($urandom_range(0, 15));
        apply({l1d, a}, {l1c, b}, "sweep");
      end
    end

    // Lane1 sweep with lane0 random.
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 16; c++) begin
        logic [3:0] a, b;
        a = 4'(i);
        b = 4'(c);
        apply({a, 4'($urandom_range(0, 15))}, {b, 4'($urandom_range(0, 15))}, "sweep1");
      end
    end

    // Mid-stream reset clears outputs regardless of inputs.
    rst_n        = 1'b0;
    in_packed    = 8'hFF;
    shift_packed = 8'h33;
    @(posedge clk);
    #1;
    check("rst2_out0", out0, 8'h00);
    check("rst2_ovf1", ovf1, 8'h00);
    rst_n = 1'b1;

    // Fully random traffic.
    for (int r = 0; r < 200; r++) begin
      apply(8'($urandom), 8'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
